// File: rtl/multicycle_controller.sv
// multicycle_controller: multicycle FSM control unit with NZCV flag register and condition gating
module multicycle_controller #(
  parameter int INSTR_W = 18,
  parameter int COND_LSB = 14,
  parameter int OP_LSB = 12,
  parameter int FUNCT_LSB = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [INSTR_W-1:0] Instr,
  input  logic [3:0]         ALUFlags,
  input  logic               MemReady,
  output logic               PCWrite,
  output logic               IRWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               AdrSrc,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         ResultSrc,
  output logic [1:0]         ALUControl,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         RegSrc,
  output logic [3:0]         Flags,
  output logic [3:0]         State
);
  typedef enum logic [3:0] {
    FETCH = 4'd0, DECODE = 4'd1, MEMADR = 4'd2, MEMREAD = 4'd3, MEMWB = 4'd4,
    MEMWRITE = 4'd5, EXECR = 4'd6, EXECI = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9
  } state_t;
  state_t state, next;
  logic [3:0] cond, funct;
  logic [1:0] op;
  logic cond_ok, cond_ex, n, z, c, v, cmp, exec, fetch_dec, unused_instr;
  assign cond = Instr[COND_LSB +: 4];
  assign op = Instr[OP_LSB +: 2];
  assign funct = Instr[FUNCT_LSB +: 4];
  assign unused_instr = ^Instr;
  assign {n, z, c, v} = Flags;
  assign cmp = op == 2'b11;
  assign exec = state == EXECR || state == EXECI;
  assign fetch_dec = state == FETCH || state == DECODE;
  always_comb begin
    case (cond)
      4'b0000: cond_ok = z;
      4'b0001: cond_ok = !z;
      4'b0010: cond_ok = c;
      4'b0011: cond_ok = !c;
      4'b0100: cond_ok = n;
      4'b0101: cond_ok = !n;
      4'b0110: cond_ok = v;
      4'b0111: cond_ok = !v;
      4'b1000: cond_ok = c && !z;
      4'b1001: cond_ok = !c || z;
      4'b1010: cond_ok = n == v;
      4'b1011: cond_ok = n != v;
      4'b1100: cond_ok = !z && n == v;
      4'b1101: cond_ok = z || n != v;
      4'b1110: cond_ok = 1'b1;
      default: cond_ok = 1'b0;
    endcase
  end
  always_comb begin
    case (state)
      FETCH:        next = MemReady ? DECODE : FETCH;
      DECODE:       next = op == 2'b01 ? MEMADR : op == 2'b10 ? BRANCH : funct[3] ? EXECI : EXECR;
      MEMADR:       next = funct[0] ? MEMREAD : MEMWRITE;
      MEMREAD:      next = MemReady ? MEMWB : MEMREAD;
      MEMWRITE:     next = (MemReady || !cond_ex) ? FETCH : MEMWRITE;
      EXECR, EXECI: next = cmp ? FETCH : ALUWB;
      default:      next = FETCH;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      Flags <= '0;
      cond_ex <= 1'b0;
    end else begin
      state <= next;
      if (state == DECODE) cond_ex <= cond_ok;
      if (exec && cond_ex && (funct[0] || cmp)) Flags <= ALUFlags;
    end
  end
  // write enables are masked during reset so an aborted instruction leaves no side effects
  assign IRWrite = !reset && state == FETCH && MemReady;
  assign PCWrite = !reset && (state == FETCH ? MemReady : state == BRANCH && cond_ex);
  assign RegWrite = !reset && (state == MEMWB || state == ALUWB) && cond_ex;
  assign MemWrite = !reset && state == MEMWRITE && cond_ex;
  assign AdrSrc = state == MEMREAD || state == MEMWRITE;
  assign ALUSrcA = fetch_dec;
  assign ALUSrcB = fetch_dec ? 2'b10 : (state == MEMADR || state == EXECI || state == BRANCH) ? 2'b01 : 2'b00;
  assign ResultSrc = (state == FETCH || state == BRANCH) ? 2'b10 : state == MEMWB ? 2'b01 : 2'b00;
  assign ALUControl = !exec ? 2'b00 : cmp ? 2'b01 : funct[2:1];
  assign ImmSrc = op;
  assign RegSrc = {op == 2'b01, op == 2'b10};
  assign State = state;
endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: per-instruction expected cycle sequences checked every cycle, plus pinned flag values
module tb_multicycle_controller;
  logic clk = 0, reset = 1, MemReady = 0;
  logic [17:0] Instr = '0, cur_instr = '0;
  logic [3:0] ALUFlags = '0;
  logic PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA;
  logic [1:0] ALUSrcB, ResultSrc, ALUControl, ImmSrc, RegSrc;
  logic [3:0] Flags, State;
  always #5 clk = ~clk;
  multicycle_controller dut (
    .clk(clk), .reset(reset), .Instr(Instr), .ALUFlags(ALUFlags), .MemReady(MemReady),
    .PCWrite(PCWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .MemWrite(MemWrite),
    .AdrSrc(AdrSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .RegSrc(RegSrc), .Flags(Flags), .State(State)
  );
  typedef struct packed {
    logic [3:0] st;
    logic pcw, irw, rw, mw, adr, asa;
    logic [1:0] asb, rs, alu, imm, rsrc;
    logic [3:0] fl;
  } exp_t;
  exp_t q[$];
  int total = 0, bad = 0, cyc = 0;
  logic [1:0] m_op = 0;
  logic [3:0] m_flags = 0;
  function automatic exp_t e(logic [3:0] st, logic pcw, logic irw, logic rw, logic mw, logic adr,
                             logic asa, logic [1:0] asb, logic [1:0] rs, logic [1:0] alu);
    return {st, pcw, irw, rw, mw, adr, asa, asb, rs, alu, m_op, m_op == 2'b01, m_op == 2'b10, m_flags};
  endfunction
  function automatic logic cpass(logic [3:0] cd, logic [3:0] f);
    logic nn, zz, cy, vv, b;
    {nn, zz, cy, vv} = f;
    case (cd[3:1])
      3'd0: b = zz;
      3'd1: b = cy;
      3'd2: b = nn;
      3'd3: b = vv;
      3'd4: b = cy & !zz;
      3'd5: b = nn == vv;
      3'd6: b = !zz && nn == vv;
      default: b = 1'b1;
    endcase
    return b ^ cd[0];
  endfunction
  task automatic step(logic mr, logic [3:0] af, logic rst, exp_t ex);
    @(posedge clk);
    #1;
    Instr = cur_instr;
    MemReady = mr;
    ALUFlags = af;
    reset = rst;
    q.push_back(ex);
  endtask
  task automatic chk(string name, logic [3:0] got, logic [3:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%b want=%b", name, got, want);
    end
  endtask
  task automatic pin(string name, logic [3:0] want_flags);
    @(posedge clk);
    #2;
    chk({name, "_flags"}, Flags, want_flags);
    chk({name, "_state"}, State, 4'd0);
  endtask
  always @(negedge clk) begin
    exp_t ex, act;
    cyc++;
    if (q.size() != 0) begin
      ex = q.pop_front();
      act = {State, PCWrite, IRWrite, RegWrite, MemWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc,
             ALUControl, ImmSrc, RegSrc, Flags};
      total++;
      if (act !== ex) begin
        bad++;
        $display("FAIL outputs cyc=%0d got=%h want=%h", cyc, act, ex);
      end
    end
  end
  task automatic run(logic [3:0] cd, logic [1:0] op, logic [3:0] fn, int fw, int mw, logic [3:0] af, logic rst_mw = 0);
    logic ce;
    m_op = op;
    cur_instr = {cd, op, fn, 8'hA5};
    ce = cpass(cd, m_flags);
    repeat (fw) step(0, 0, 0, e(4'd0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0));
    step(1, 0, 0, e(4'd0, 1, 1, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0));
    step(0, 0, 0, e(4'd1, 0, 0, 0, 0, 0, 1, 2'd2, 2'd0, 2'd0));
    if (op == 2'd1) begin
      step(0, 0, 0, e(4'd2, 0, 0, 0, 0, 0, 0, 2'd1, 2'd0, 2'd0));
      if (fn[0]) begin
        repeat (mw) step(0, 0, 0, e(4'd3, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0));
        step(1, 0, 0, e(4'd3, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0));
        step(0, 0, 0, e(4'd4, 0, 0, ce, 0, 0, 0, 2'd0, 2'd1, 2'd0));
      end else if (!ce) begin
        step(0, 0, 0, e(4'd5, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0));
      end else if (rst_mw) begin
        step(0, 0, 0, e(4'd5, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0));
        step(0, 0, 1, e(4'd5, 0, 0, 0, 0, 1, 0, 2'd0, 2'd0, 2'd0));
        m_flags = 0;
      end else begin
        repeat (mw) step(0, 0, 0, e(4'd5, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0));
        step(1, 0, 0, e(4'd5, 0, 0, 0, 1, 1, 0, 2'd0, 2'd0, 2'd0));
      end
    end else if (op == 2'd2) begin
      step(0, 0, 0, e(4'd9, ce, 0, 0, 0, 0, 0, 2'd1, 2'd2, 2'd0));
    end else begin
      step(0, af, 0, e(fn[3] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 0, fn[3] ? 2'd1 : 2'd0, 2'd0,
                       op == 2'd3 ? 2'd1 : fn[2:1]));
      if (ce && (fn[0] || op == 2'd3)) m_flags = af;
      if (op != 2'd3) step(0, 0, 0, e(4'd8, 0, 0, ce, 0, 0, 0, 2'd0, 2'd0, 2'd0));
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    step(1, 0, 1, e(4'd0, 0, 0, 0, 0, 0, 1, 2'd2, 2'd2, 2'd0));
    run(4'hE, 2'd0, 4'b1000, 0, 0, 4'h0);
    pin("addi", 4'b0000);
    run(4'hE, 2'd0, 4'b0000, 2, 0, 4'hF);
    run(4'hE, 2'd1, 4'b0001, 0, 3, 4'h0);
    run(4'hE, 2'd1, 4'b0000, 0, 2, 4'h0);
    run(4'hE, 2'd3, 4'b0000, 0, 0, 4'b0100);
    pin("cmp", 4'b0100);
    run(4'h0, 2'd2, 4'b0000, 0, 0, 4'h0);
    run(4'h1, 2'd2, 4'b0000, 0, 0, 4'h0);
    run(4'hF, 2'd1, 4'b0000, 0, 2, 4'h0);
    run(4'hF, 2'd0, 4'b0001, 0, 0, 4'b1010);
    pin("nv_adds", 4'b0100);
    run(4'hE, 2'd0, 4'b0011, 1, 0, 4'b1001);
    pin("subs", 4'b1001);
    run(4'hC, 2'd0, 4'b0110, 0, 0, 4'h0);
    run(4'hB, 2'd0, 4'b1100, 0, 0, 4'h0);
    run(4'hE, 2'd1, 4'b0000, 0, 0, 4'h0, 1);
    pin("reset_mw", 4'b0000);
    run(4'hE, 2'd0, 4'b1000, 1, 0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain got=%0d want=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
